// File: rtl/jetson_spi_slave_if.sv
// Command strobe, reply FIFO push port and status bundle between the Jetson SPI
// slave and the peripheral dispatcher / reply arbiter.
interface jetson_spi_slave_if #(
    parameter int FIFO_AW = 3
);
    logic             cmd_valid;
    logic [3:0]       cmd_id;
    logic [27:0]      cmd_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [3:0]       rsp_id;
    logic [27:0]      rsp_data;
    logic [27:0]      idle_word;
    logic [FIFO_AW:0] rsp_level;
    logic             irq;
    logic             frame_err;

    modport slave (
        output cmd_valid, cmd_id, cmd_data, rsp_ready, rsp_level, irq, frame_err,
        input  rsp_valid, rsp_id, rsp_data, idle_word
    );

    modport master (
        input  cmd_valid, cmd_id, cmd_data, rsp_ready, rsp_level, irq, frame_err,
        output rsp_valid, rsp_id, rsp_data, idle_word
    );
endinterface

// File: rtl/jetson_spi_slave.sv
// SPI mode-0 slave for the Jetson command link: 32-bit full-duplex frames, reply FIFO.
// Optional macro JLINK_CS_TIMEOUT_EN aborts a frame after TIMEOUT_CYCLES of sclk inactivity.
module jetson_spi_slave #(
    parameter int FIFO_AW        = 3,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_clk_i,
    input  logic              spi_mosi_i,
    input  logic              spi_cs_n_i,
    output logic              spi_miso_o,
    jetson_spi_slave_if.slave bus
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   FULL_LVL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   LVL_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

    if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("jetson_spi_slave: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {IDLE, SHIFT, DONE, WAIT_CS} state_e;

    // The cs_n chain resets low so a select already held low after reset
    // produces no falling edge: the link re-arms only after cs_n is seen high.
    logic [SYNC_STAGES:0]   sclk_q, csn_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= '0;
            csn_q  <= '0;
            mosi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-1:0], spi_clk_i};
            csn_q  <= {csn_q[SYNC_STAGES-1:0], spi_cs_n_i};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi_i};
        end
    end

    assign sclk_rise =  sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
    assign sclk_fall = ~sclk_q[SYNC_STAGES-1] &  sclk_q[SYNC_STAGES];
    assign cs_rise   =  csn_q[SYNC_STAGES-1]  & ~csn_q[SYNC_STAGES];
    assign cs_fall   = ~csn_q[SYNC_STAGES-1]  &  csn_q[SYNC_STAGES];
    assign mosi_s    =  mosi_q[SYNC_STAGES-1];

    state_e             state_q, state_d;
    logic [31:0]        tx_q, tx_d, rx_q, rx_d;
    logic [5:0]         cnt_q, cnt_d;
    logic               extra_q, extra_d, loaded_q, loaded_d;
    logic               commit, abort, timeout, push, pop;
    logic               cmd_valid_q, frame_err_q;
    logic [3:0]         cmd_id_q;
    logic [27:0]        cmd_data_q;
    logic [31:0]        mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   level_q;

`ifdef JLINK_CS_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] idle_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idle_cnt_q <= '0;
        else if (state_q != SHIFT || sclk_rise || sclk_fall)
            idle_cnt_q <= '0;
        else if (idle_cnt_q != TO_W'(TIMEOUT_CYCLES))
            idle_cnt_q <= idle_cnt_q + TO_W'(1);
    end

    assign timeout = (state_q == SHIFT) && (idle_cnt_q == TO_W'(TIMEOUT_CYCLES));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        cnt_d    = cnt_q;
        extra_d  = extra_q;
        loaded_d = loaded_q;
        commit   = 1'b0;
        abort    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    loaded_d = (level_q != '0);
                    tx_d     = loaded_d ? mem_q[rd_ptr_q] : {4'h0, bus.idle_word};
                    cnt_d    = '0;
                    extra_d  = 1'b0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    rx_d  = {rx_q[30:0], mosi_s};
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) state_d = DONE;
                end else if (sclk_fall) begin
                    tx_d = {tx_q[30:0], 1'b0};
                end else if (timeout) begin
                    abort   = 1'b1;
                    state_d = WAIT_CS;
                end
            end
            DONE: begin
                if (sclk_rise) extra_d = 1'b1;
                if (cs_rise) begin
                    commit  = ~extra_q;
                    abort   =  extra_q;
                    state_d = IDLE;
                end
            end
            WAIT_CS: begin
                if (csn_q[SYNC_STAGES-1]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign push = bus.rsp_valid && bus.rsp_ready;
    assign pop  = commit && loaded_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            extra_q     <= 1'b0;
            loaded_q    <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_id_q    <= '0;
            cmd_data_q  <= '0;
            frame_err_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            extra_q     <= extra_d;
            loaded_q    <= loaded_d;
            frame_err_q <= abort;
            cmd_valid_q <= commit && (rx_q[31:28] != 4'h0);
            if (commit && (rx_q[31:28] != 4'h0)) begin
                cmd_id_q   <= rx_q[31:28];
                cmd_data_q <= rx_q[27:0];
            end
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_ONE;
                2'b01:   level_q <= level_q - LVL_ONE;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        tx_q <= tx_d;
        rx_q <= rx_d;
        if (push) mem_q[wr_ptr_q] <= {bus.rsp_id, bus.rsp_data};
    end

    // miso is only meaningful while shifting; tx_q[31] is the bit on the wire.
    assign spi_miso_o    = (state_q == SHIFT) && tx_q[31];
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_id    = cmd_id_q;
    assign bus.cmd_data  = cmd_data_q;
    assign bus.frame_err = frame_err_q;
    assign bus.rsp_level = level_q;
    assign bus.irq       = (level_q != '0);
    assign bus.rsp_ready = (level_q != FULL_LVL);
endmodule

// File: tb/tb_jetson_spi_slave.sv
// Scoreboard bench for jetson_spi_slave: queue-based reply model, SPI master
// tasks, and independent monitors for miso words, command strobes and frame errors.
`timescale 1ns/1ps
module tb_jetson_spi_slave;
    localparam int FIFO_AW  = 3;
`ifdef JLINK_CS_TIMEOUT_EN
    localparam int TO_CYC   = 64;
`else
    localparam int TO_CYC   = 4096;
`endif
    localparam int HALF     = 200;
    localparam int STALL_NS = 70 * 20;

    logic clk = 1'b0, rst_n = 1'b0;
    logic spi_clk = 1'b0, spi_mosi = 1'b0, spi_cs_n = 1'b1, spi_miso;

    jetson_spi_slave_if #(.FIFO_AW(FIFO_AW)) bus();

    jetson_spi_slave #(.FIFO_AW(FIFO_AW), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi_clk_i  (spi_clk),
        .spi_mosi_i (spi_mosi),
        .spi_cs_n_i (spi_cs_n),
        .spi_miso_o (spi_miso),
        .bus        (bus)
    );

    always #10 clk = ~clk;

    typedef struct { bit chk; logic [31:0] w; } mexp_t;

    int          checks = 0, errors = 0;
    int          ferr_seen = 0, ferr_exp = 0;
    bit          mon_en = 1'b0;
    mexp_t       mq[$];
    logic [31:0] cq[$];
    logic [31:0] model[$];
    logic [31:0] mword;
    int          mbits;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Command strobe and frame error monitor.
    always @(negedge clk) begin
        if (bus.frame_err) ferr_seen++;
        if (bus.cmd_valid) begin
            if (cq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cmd_unexpected: got id %h data %h, expected no strobe", bus.cmd_id, bus.cmd_data);
            end else begin
                check("cmd", {bus.cmd_id, bus.cmd_data}, cq.pop_front());
            end
        end
    end

    // Master-side miso capture, compared once per frame.
    always @(negedge spi_cs_n) if (mon_en) begin
        mbits = 0;
        mword = '0;
    end
    always @(posedge spi_clk) if (mon_en && !spi_cs_n) begin
        mword = {mword[30:0], spi_miso};
        mbits++;
    end
    always @(posedge spi_cs_n) if (mon_en) begin
        mexp_t e;
        if (mq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL miso_unexpected: got %h with no frame expected", mword);
        end else begin
            e = mq.pop_front();
            if (e.chk) begin
                check("miso_bits", mbits, 32);
                check("miso_word", mword, e.w);
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation exceeded time limit, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic push_rsp(input logic [31:0] w);
        @(negedge clk);
        check("rsp_ready", 32'(bus.rsp_ready), 32'(model.size() < 8));
        bus.rsp_id    = w[31:28];
        bus.rsp_data  = w[27:0];
        bus.rsp_valid = 1'b1;
        @(negedge clk);
        bus.rsp_valid = 1'b0;
        if (model.size() < 8) model.push_back(w);
    endtask

    task automatic spi_xfer(input logic [31:0] tx, input int nbits, input int stall_at,
                            input bit push_mid, input logic [31:0] pw);
        @(negedge clk);
        #3;
        spi_cs_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = (i < 32) ? tx[31-i] : 1'b0;
            if (i == stall_at) #(STALL_NS);
            if (push_mid && i == 16) begin
                push_rsp(pw);
                @(negedge clk);
                #3;
            end
            #(HALF) spi_clk = 1'b1;
            #(HALF) spi_clk = 1'b0;
        end
        #(HALF) spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic full_frame(input logic [3:0] id, input logic [27:0] d, input int stall_at,
                              input bit push_mid, input logic [31:0] pw);
        logic [31:0] exp_w;
        bit          loaded, commit;
        loaded = (model.size() != 0);
        exp_w  = loaded ? model[0] : {4'h0, bus.idle_word};
        commit = 1'b1;
`ifdef JLINK_CS_TIMEOUT_EN
        if (stall_at >= 0) commit = 1'b0;
`endif
        mq.push_back('{commit, exp_w});
        if (commit && id != 4'h0) cq.push_back({id, d});
        if (!commit) ferr_exp++;
        spi_xfer({id, d}, 32, stall_at, push_mid, pw);
        if (commit && loaded) void'(model.pop_front());
    endtask

    task automatic bad_frame(input logic [31:0] tx, input int nbits);
        mq.push_back('{1'b0, 32'h0});
        ferr_exp++;
        spi_xfer(tx, nbits, -1, 1'b0, 32'h0);
    endtask

    task automatic check_status(input string tag);
        repeat (2) @(negedge clk);
        check({tag, "_level"}, 32'(bus.rsp_level), model.size());
        check({tag, "_irq"}, 32'(bus.irq), 32'(model.size() != 0));
        check({tag, "_ready"}, 32'(bus.rsp_ready), 32'(model.size() < 8));
        check({tag, "_ferr"}, ferr_seen, ferr_exp);
    endtask

    initial begin
        bus.rsp_valid = 1'b0;
        bus.rsp_id    = '0;
        bus.rsp_data  = '0;
        bus.idle_word = 28'hB00_0000;
        repeat (3) @(negedge clk);
        check("rst_miso", 32'(spi_miso), 0);
        check("rst_cmd_valid", 32'(bus.cmd_valid), 0);
        check("rst_cmd_id", 32'(bus.cmd_id), 0);
        check("rst_cmd_data", 32'(bus.cmd_data), 0);
        check("rst_rsp_ready", 32'(bus.rsp_ready), 1);
        check("rst_rsp_level", 32'(bus.rsp_level), 0);
        check("rst_irq", 32'(bus.irq), 0);
        check("rst_frame_err", 32'(bus.frame_err), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;

        // Empty FIFO returns the idle word; command is strobed
        full_frame(4'hE, 28'h000_0001, -1, 1'b0, 32'h0);
        check_status("t1");

        // Queued reply returned during a Nop frame
        push_rsp(32'h3002_0005);
        check_status("t2_pre");
        full_frame(4'h0, 28'h123_4567, -1, 1'b0, 32'h0);
        check_status("t2_post");

        // Fill, overflow, drain in order
        for (int i = 0; i < 9; i++) push_rsp({4'(i + 1), 28'(i * 28'h11_1111 + 28'h7)});
        check_status("t3_full");
        for (int i = 0; i < 9; i++) full_frame(4'(i + 5), 28'($urandom), -1, 1'b0, 32'h0);
        check_status("t3_drain");

        // Short frame keeps the head, next frame resends it
        push_rsp(32'h7ABC_DEF0);
        bad_frame(32'h5000_0055, 12);
        check_status("t4_short");
        full_frame(4'h6, 28'h00F_00F0, -1, 1'b0, 32'h0);
        check_status("t4_resend");

        // 33-clock frame rejected, no pop
        push_rsp(32'h4444_0001);
        bad_frame(32'h2AAA_AAAA, 33);
        check_status("t5_long");

        // Mid-frame stall: aborted when the timeout is built in, accepted otherwise
        full_frame(4'h5, 28'h0C0_FFEE, 10, 1'b0, 32'h0);
        check_status("t6_stall");
        full_frame(4'h9, 28'h000_0099, -1, 1'b0, 32'h0);
        check_status("t6_after");

        // Push landing in an empty FIFO during an idle-word frame goes out next frame
        for (int i = 0; i < 8 && model.size() != 0; i++)
            full_frame(4'h0, 28'h0, -1, 1'b0, 32'h0);
        bus.idle_word = 28'h5A5_A5A5;
        full_frame(4'h1, 28'h111_1111, -1, 1'b1, 32'hC0DE_0042);
        check_status("t7_mid");
        full_frame(4'h2, 28'h222_2222, -1, 1'b0, 32'h0);
        check_status("t7_next");

        // Reset mid-frame, cs_n held low across reset: no activity until re-armed
        push_rsp(32'h90AB_CDEF);
        @(negedge clk);
        #3;
        mq.push_back('{1'b0, 32'h0});
        spi_cs_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            spi_mosi = 1'($urandom_range(0, 1));
            #(HALF) spi_clk = 1'b1;
            #(HALF) spi_clk = 1'b0;
        end
        rst_n = 1'b0;
        model.delete();
        repeat (2) @(negedge clk);
        check("rstmid_level", 32'(bus.rsp_level), 0);
        check("rstmid_miso", 32'(spi_miso), 0);
        check("rstmid_irq", 32'(bus.irq), 0);
        rst_n = 1'b1;
        @(negedge clk);
        #3;
        for (int i = 0; i < 32; i++) begin
            spi_mosi = (i < 4) ? 1'b1 : 1'($urandom_range(0, 1));
            #(HALF) spi_clk = 1'b1;
            #(HALF) spi_clk = 1'b0;
        end
        #(HALF) spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (12) @(negedge clk);
        check_status("rstmid_rearm");

        // Randomized mix of pushes and frames
        for (int n = 0; n < 16; n++) begin
            if ($urandom_range(0, 2) == 0 && model.size() < 8) begin
                push_rsp($urandom);
            end else begin
                logic [3:0] id;
                id = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                bus.idle_word = 28'($urandom);
                full_frame(id, 28'($urandom), -1, 1'b0, 32'h0);
            end
            if (n % 4 == 3) check_status("rand");
        end
        check_status("final");
        check("final_cmd_queue", cq.size(), 0);
        check("final_miso_queue", mq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/jetson_spi_slave.md
Name: jetson_spi_slave

Overview:
- SPI slave endpoint of the Jetson command link. Receives 32-bit frames {id[3:0], data[27:0]}, MSB first, from the Jetson SPI master, and presents each non-Nop frame as a one-cycle command strobe to the peripheral dispatcher.
- In the same full-duplex transfer, shifts out the head of a reply FIFO filled by peripherals (sonar, motor, ADC, radio, RC). When the FIFO is empty it shifts out a Nop frame carrying a status word.
- Sits between the top-level Jetson pins and the command decoder / reply arbiter.

Parameters:
- FIFO_AW, 3, log2 of reply FIFO depth (8 entries).
- SYNC_STAGES, 2, synchronizer flops on spi_clk, spi_mosi and spi_cs_n (minimum 2).
- TIMEOUT_CYCLES, 4096, clk cycles of spi_clk inactivity with CS low before the frame is aborted (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- spi_clk  in  1  Jetson SPI clock, mode 0 (idle low), asynchronous to clk.
- spi_mosi  in  1  Jetson to FPGA data.
- spi_cs_n  in  1  frame select, active low.
- spi_miso  out  1  FPGA to Jetson data.
- cmd_valid  out  1  one-cycle strobe: a complete non-Nop frame was received.
- cmd_id  out  4  frame ID; held until the next cmd_valid.
- cmd_data  out  28  frame payload; held until the next cmd_valid.
- rsp_valid  in  1  peripheral reply push request.
- rsp_ready  out  1  equals "FIFO not full".
- rsp_id  in  4  reply ID.
- rsp_data  in  28  reply payload.
- idle_word  in  28  payload sent with ID 0 when the FIFO is empty.
- rsp_level  out  FIFO_AW+1  current FIFO occupancy.
- irq  out  1  high while the FIFO is non-empty.
- frame_err  out  1  one-cycle strobe when a frame is aborted or has the wrong length.

Behaviour:
- Reset values: spi_miso=0, cmd_valid=0, cmd_id=0, cmd_data=0, rsp_ready=1, rsp_level=0, irq=0, frame_err=0. The FIFO is emptied and the bit counter cleared.
- Synchronization: all SPI inputs pass through SYNC_STAGES flops. Edges are detected from the last two synchronized samples. The spi_clk period must be at least 8 clk cycles; the bench uses 20 ns clk and SPI period of 200 ns or more.
- States:
  - IDLE: spi_miso=0. On cs_n falling edge, load tx_sh with {head_id, head_data} if FIFO non-empty, otherwise {4'h0, idle_word} (idle_word sampled at this edge). Set bit_cnt=0, drive tx_sh[31] onto miso, go to SHIFT.
  - SHIFT:
    - sclk rising: rx_sh <= {rx_sh[30:0], mosi}; bit_cnt+1.
    - sclk falling: tx_sh shifts left; miso = new tx_sh[31].
    - After the 32nd rising edge, go to DONE.
  - DONE:
    - Ignore further sclk edges; miso=0.
    - On cs_n rising edge: if no extra rising edges were seen, commit. Otherwise pulse frame_err without committing. Then go to IDLE.
  - Commit, 1 clk after the cs_n rising edge is detected:
    - If rx id != 0, pulse cmd_valid and update cmd_id/cmd_data. Nop frames produce no strobe.
    - If the FIFO head was loaded at frame start, pop it.
- cs_n rising while in SHIFT (fewer than 32 bits): pulse frame_err, no cmd_valid, no pop. The reply stays at the head and is resent in the next frame.
- Reply FIFO:
  - Push when rsp_valid && rsp_ready.
  - A push and a pop in the same cycle leaves the level unchanged.
  - A push that lands in an empty FIFO during a frame that loaded idle_word is not sent in that frame; it goes in the next one.
  - Pointers wrap modulo 2^FIFO_AW.
  - rsp_level, irq and rsp_ready update 1 cycle after a push or pop.
- Reset asserted mid-frame: everything returns to reset values immediately. The partial frame is discarded, and SPI activity is ignored until cs_n has been seen high (re-arm).

Optional Feature:
- Macro: JLINK_CS_TIMEOUT_EN.
- Defined: in SHIFT, an idle counter counts clk cycles since the last sclk edge. When it reaches TIMEOUT_CYCLES, the frame is aborted: frame_err pulses, no commit occurs, and the block waits for cs_n high before returning to IDLE.
- Not defined: the counter is absent, and SHIFT waits indefinitely for sclk or cs_n.

Test Plan:
1. FIFO empty, idle_word=28'hB00_0000. Master sends {4'hE, 28'h000_0001} -> master receives 32'h0B00_0000; cmd_valid pulses once with cmd_id=4'hE, cmd_data=28'h1.
2. Push {4'h3, 28'h002_0005}; irq=1, rsp_level=1. Master sends a Nop frame -> master receives 32'h3002_0005; no cmd_valid; after commit irq=0, rsp_level=0.
3. Push 8 replies -> rsp_ready=0 and a 9th push is ignored. Read 8 frames -> replies come back in push order, then idle_word.
4. One reply queued; master raises cs_n after 12 bits -> frame_err pulses, no cmd_valid, rsp_level stays 1. The next full frame returns the same reply.
5. Frame of 33 clocks with ID 2 -> frame_err pulses, no cmd_valid, no pop.
6. JLINK_CS_TIMEOUT_EN defined, TIMEOUT_CYCLES=64; master stalls 70 clk mid-frame -> frame_err pulses, no commit. After cs_n high, a normal frame is accepted.
